// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core array, mem_port_arbiter and one data_memory port.
// master = core/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        req_write;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*DATA_W-1:0] req_data;
  logic [NUM_CORES-1:0]        lock;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        resp_valid;
  logic [DATA_W-1:0]           resp_data;
  logic [1:0]                  mem_control;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_data_in;
  logic [DATA_W-1:0]           mem_data_out;

  modport master (
    output req, req_write, req_addr, req_data, lock, mem_data_out,
    input  grant, resp_valid, resp_data, mem_control, mem_addr, mem_data_in
  );

  modport slave (
    input  req, req_write, req_addr, req_data, lock, mem_data_out,
    output grant, resp_valid, resp_data, mem_control, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data_memory port among NUM_CORES cores.
// Owner locking is compiled in only when MEM_ARB_LOCK_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LOCK_MAX  = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned PTR_W      = $clog2(NUM_CORES);
  localparam logic [1:0]  CTRL_IDLE  = 2'd0;
  localparam logic [1:0]  CTRL_READ  = 2'd2;
  localparam logic [1:0]  CTRL_WRITE = 2'd3;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t               state, state_next;
  logic [PTR_W-1:0]     ptr, ptr_next;
  logic [PTR_W-1:0]     win;
  logic                 found;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] grant_next;
  logic [1:0]           ctrl_next;
  logic [ADDR_W-1:0]    addr_next;
  logic [DATA_W-1:0]    data_next;

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  logic [PTR_W-1:0] owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock ^ (LOCK_MAX == 0);
`endif

  function automatic logic [PTR_W-1:0] step_index(input logic [PTR_W-1:0] i);
    return (32'(i) == NUM_CORES - 1) ? '0 : i + 1'b1;
  endfunction

  // A core whose grant is visible this cycle is masked so its held Req is not re-served.
  always_comb begin
    eligible = bus.req & ~bus.grant;
`ifdef MEM_ARB_LOCK_EN
    if (state == LOCKED) eligible = eligible & (NUM_CORES'(1) << owner);
`endif
  end

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && eligible[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = '0;
    ctrl_next  = CTRL_IDLE;
    addr_next  = bus.mem_addr;
    data_next  = bus.mem_data_in;
`ifdef MEM_ARB_LOCK_EN
    owner_next = owner;
    cnt_next   = cnt;
`endif
    if (found) begin
      grant_next[win] = 1'b1;
      ctrl_next       = bus.req_write[win] ? CTRL_WRITE : CTRL_READ;
      addr_next       = bus.req_addr[32'(win) * ADDR_W +: ADDR_W];
      data_next       = bus.req_data[32'(win) * DATA_W +: DATA_W];
      ptr_next        = step_index(win);
`ifdef MEM_ARB_LOCK_EN
      case (state)
        ARB: begin
          if (bus.lock[win] && LOCK_MAX > 1) begin
            state_next = LOCKED;
            owner_next = win;
            cnt_next   = CNT_W'(1);
            ptr_next   = win;
          end
        end
        LOCKED: begin
          if (!bus.lock[win] || (32'(cnt) + 1 >= LOCK_MAX)) begin
            state_next = ARB;
            cnt_next   = '0;
            ptr_next   = step_index(win);
          end else begin
            cnt_next = cnt + 1'b1;
            ptr_next = win;
          end
        end
        default: state_next = ARB;
      endcase
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ARB;
      ptr             <= '0;
      bus.grant       <= '0;
      bus.resp_valid  <= '0;
      bus.mem_control <= CTRL_IDLE;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
    end else begin
      state           <= state_next;
      ptr             <= ptr_next;
      bus.grant       <= grant_next;
      // The memory samples the read issued this cycle; its data is visible next cycle.
      bus.resp_valid  <= (bus.mem_control == CTRL_READ) ? bus.grant : '0;
      bus.mem_control <= ctrl_next;
      bus.mem_addr    <= addr_next;
      bus.mem_data_in <= data_next;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      cnt   <= '0;
    end else begin
      owner <= owner_next;
      cnt   <= cnt_next;
    end
  end
`endif

  assign bus.resp_data = bus.mem_data_out;

endmodule
